// File: rtl/vm2002_common_pkg.sv
// Shared types and coin values for the vm2002 change controller.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_t;

  localparam int unsigned NICKEL_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    DONE,
    SHORT
  } change_state_t;

endpackage

// File: rtl/vm2002_coin_inventory.sv
// Hopper inventory: three saturating coin counters with restock-add and
// single-coin decrement.
module vm2002_coin_inventory
  import vm2002_common_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             restock_en,
  input  coin_t            restock_type,
  input  logic [CNT_W-1:0] restock_count,
  input  logic             dec_en,
  input  coin_t            dec_type,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] quarter_cnt,
  output logic             nickel_nz,
  output logic             dime_nz,
  output logic             quarter_nz
);

  logic [CNT_W-1:0] nickel_q, nickel_d;
  logic [CNT_W-1:0] dime_q, dime_d;
  logic [CNT_W-1:0] quarter_q, quarter_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Restock only happens in IDLE and decrement only in ISSUE, so they never overlap.
  always_comb begin
    nickel_d  = nickel_q;
    dime_d    = dime_q;
    quarter_d = quarter_q;
    if (restock_en) begin
      case (restock_type)
        NICKEL:  nickel_d  = sat_add(nickel_q, restock_count);
        DIME:    dime_d    = sat_add(dime_q, restock_count);
        QUARTER: quarter_d = sat_add(quarter_q, restock_count);
        default: ;
      endcase
    end
    if (dec_en) begin
      case (dec_type)
        NICKEL:  if (nickel_q != '0)  nickel_d  = nickel_q - CNT_W'(1);
        DIME:    if (dime_q != '0)    dime_d    = dime_q - CNT_W'(1);
        QUARTER: if (quarter_q != '0) quarter_d = quarter_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      nickel_q  <= '0;
      dime_q    <= '0;
      quarter_q <= '0;
    end else begin
      nickel_q  <= nickel_d;
      dime_q    <= dime_d;
      quarter_q <= quarter_d;
    end
  end

  assign nickel_cnt  = nickel_q;
  assign dime_cnt    = dime_q;
  assign quarter_cnt = quarter_q;
  assign nickel_nz   = (nickel_q != '0);
  assign dime_nz     = (dime_q != '0);
  assign quarter_nz  = (quarter_q != '0);

endmodule

// File: rtl/vm2002_change_ctrl.sv
// Greedy quarter/dime/nickel change dispenser driving a single coin hopper.
// Optional hopper ack timeout and fault port: define VM2002_HOPPER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start; restock allowed
// SELECT | pick largest coin that fits remaining and is in stock
// ISSUE  | coin_req high until coin_ack (or timeout)
// DONE   | done pulse, balance fully returned
// SHORT  | done pulse with short_change, remaining holds unpaid cents
module vm2002_change_ctrl
  import vm2002_common_pkg::*;
#(
  parameter int AMT_W = 16,
  parameter int CNT_W = 8
`ifdef VM2002_HOPPER_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = 255
`endif
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] balance,
  input  logic             restock,
  input  logic [1:0]       restock_type,
  input  logic [CNT_W-1:0] restock_count,
  output logic             coin_req,
  output logic [1:0]       coin_type,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             short_change,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] quarter_cnt
`ifdef VM2002_HOPPER_TIMEOUT_EN
  ,
  output logic             fault
`endif
);

  change_state_t    state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  coin_t            coin_sel_q, coin_sel_d;
  logic [AMT_W-1:0] coin_val;
  logic             dec_en;
  logic             nickel_nz, dime_nz, quarter_nz;

`ifdef VM2002_HOPPER_TIMEOUT_EN
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic             fault_q, fault_d;
`endif

  vm2002_coin_inventory #(.CNT_W(CNT_W)) u_inventory (
    .clk          (clk),
    .hrst_n       (hrst_n),
    .restock_en   (restock && (state_q == IDLE)),
    .restock_type (coin_t'(restock_type)),
    .restock_count(restock_count),
    .dec_en       (dec_en),
    .dec_type     (coin_sel_q),
    .nickel_cnt   (nickel_cnt),
    .dime_cnt     (dime_cnt),
    .quarter_cnt  (quarter_cnt),
    .nickel_nz    (nickel_nz),
    .dime_nz      (dime_nz),
    .quarter_nz   (quarter_nz)
  );

  always_comb begin
    case (coin_sel_q)
      QUARTER: coin_val = AMT_W'(QUARTER_VAL);
      DIME:    coin_val = AMT_W'(DIME_VAL);
      NICKEL:  coin_val = AMT_W'(NICKEL_VAL);
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_sel_d  = coin_sel_q;
    dec_en      = 1'b0;
`ifdef VM2002_HOPPER_TIMEOUT_EN
    ack_cnt_d   = '0;
    fault_d     = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = balance;
          state_d     = SELECT;
`ifdef VM2002_HOPPER_TIMEOUT_EN
          fault_d     = 1'b0;
`endif
        end
      end
      SELECT: begin
        coin_sel_d = NONE;
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (remaining_q >= AMT_W'(QUARTER_VAL) && quarter_nz) begin
          state_d    = ISSUE;
          coin_sel_d = QUARTER;
        end else if (remaining_q >= AMT_W'(DIME_VAL) && dime_nz) begin
          state_d    = ISSUE;
          coin_sel_d = DIME;
        end else if (remaining_q >= AMT_W'(NICKEL_VAL) && nickel_nz) begin
          state_d    = ISSUE;
          coin_sel_d = NICKEL;
        end else begin
          state_d = SHORT;
        end
      end
      ISSUE: begin
        if (coin_ack) begin
          dec_en      = 1'b1;
          remaining_d = remaining_q - coin_val;
          coin_sel_d  = NONE;
          state_d     = SELECT;
        end
`ifdef VM2002_HOPPER_TIMEOUT_EN
        else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          coin_sel_d = NONE;
          fault_d    = 1'b1;
          state_d    = SHORT;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      SHORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coin_sel_q  <= NONE;
`ifdef VM2002_HOPPER_TIMEOUT_EN
      ack_cnt_q   <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_sel_q  <= coin_sel_d;
`ifdef VM2002_HOPPER_TIMEOUT_EN
      ack_cnt_q   <= ack_cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  // Outputs decode straight from state so an async reset drops coin_req at once.
  assign coin_req     = (state_q == ISSUE);
  assign coin_type    = coin_sel_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE) || (state_q == SHORT);
  assign short_change = (state_q == SHORT);
  assign remaining    = remaining_q;
`ifdef VM2002_HOPPER_TIMEOUT_EN
  assign fault        = fault_q;
`endif

endmodule

// File: tb/tb_vm2002_change_ctrl.sv
// Directed bench for vm2002_change_ctrl with an auto-acking hopper model.
module tb_vm2002_change_ctrl;
  localparam int AMT_W = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             hrst_n;
  logic             start;
  logic [AMT_W-1:0] balance;
  logic             restock;
  logic [1:0]       restock_type;
  logic [CNT_W-1:0] restock_count;
  logic             coin_req;
  logic [1:0]       coin_type;
  logic             coin_ack;
  logic             busy;
  logic             done;
  logic             short_change;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] nickel_cnt, dime_cnt, quarter_cnt;
`ifdef VM2002_HOPPER_TIMEOUT_EN
  logic             fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic ack_en = 1'b1;
  logic [1:0] coin_log[$];

  vm2002_change_ctrl #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .hrst_n       (hrst_n),
    .start        (start),
    .balance      (balance),
    .restock      (restock),
    .restock_type (restock_type),
    .restock_count(restock_count),
    .coin_req     (coin_req),
    .coin_type    (coin_type),
    .coin_ack     (coin_ack),
    .busy         (busy),
    .done         (done),
    .short_change (short_change),
    .remaining    (remaining),
    .nickel_cnt   (nickel_cnt),
    .dime_cnt     (dime_cnt),
    .quarter_cnt  (quarter_cnt)
`ifdef VM2002_HOPPER_TIMEOUT_EN
    ,
    .fault        (fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hopper: acks in the first cycle it sees a request.
  always @(negedge clk) coin_ack = ack_en && coin_req;

  always @(posedge clk)
    if (hrst_n && coin_req && coin_ack) coin_log.push_back(coin_type);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] coin_at(input int i);
    if (i < coin_log.size()) return coin_log[i];
    return 2'bxx;
  endfunction

  task automatic do_reset();
    hrst_n = 1'b0;
    repeat (2) @(negedge clk);
    hrst_n = 1'b1;
    coin_log.delete();
  endtask

  task automatic do_restock(input logic [1:0] t, input logic [CNT_W-1:0] c);
    @(negedge clk);
    restock = 1'b1; restock_type = t; restock_count = c;
    @(negedge clk);
    restock = 1'b0; restock_type = 2'd0; restock_count = '0;
  endtask

  task automatic start_pulse(input logic [AMT_W-1:0] b);
    @(negedge clk);
    start = 1'b1; balance = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    hrst_n = 1'b1; start = 1'b0; balance = '0;
    restock = 1'b0; restock_type = 2'd0; restock_count = '0;
    coin_ack = 1'b0;
    #2;
    hrst_n = 1'b0;
    #1;
    check("rst_req", {31'd0, coin_req}, 32'd0);
    check("rst_type", {30'd0, coin_type}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rem", {16'd0, remaining}, 32'd0);
    check("rst_q", {24'd0, quarter_cnt}, 32'd0);
    do_reset();

    // 40c with plenty of stock: Q, D, N in order
    do_restock(2'd3, 8'd5);
    do_restock(2'd2, 8'd5);
    do_restock(2'd1, 8'd5);
    start_pulse(16'd40);
    wait_done("t40");
    check("t40_short", {31'd0, short_change}, 32'd0);
    check("t40_rem", {16'd0, remaining}, 32'd0);
    check("t40_ncoin", coin_log.size(), 32'd3);
    check("t40_c0", {30'd0, coin_at(0)}, 32'd3);
    check("t40_c1", {30'd0, coin_at(1)}, 32'd2);
    check("t40_c2", {30'd0, coin_at(2)}, 32'd1);
    @(negedge clk);
    check("t40_q", {24'd0, quarter_cnt}, 32'd4);
    check("t40_d", {24'd0, dime_cnt}, 32'd4);
    check("t40_n", {24'd0, nickel_cnt}, 32'd4);
    check("t40_idle", {31'd0, busy}, 32'd0);

    // zero balance: SELECT then DONE, no request
    coin_log.delete();
    start_pulse(16'd0);
    check("z_c1_busy", {31'd0, busy}, 32'd1);
    check("z_c1_done", {31'd0, done}, 32'd0);
    check("z_c1_req", {31'd0, coin_req}, 32'd0);
    @(negedge clk);
    check("z_c2_done", {31'd0, done}, 32'd1);
    check("z_c2_busy", {31'd0, busy}, 32'd1);
    check("z_c2_short", {31'd0, short_change}, 32'd0);
    @(negedge clk);
    check("z_c3_busy", {31'd0, busy}, 32'd0);
    check("z_c3_done", {31'd0, done}, 32'd0);
    check("z_ncoin", coin_log.size(), 32'd0);

    // greedy failure: 30 with Q=0 D=1 N=1 shorts at 15
    do_reset();
    do_restock(2'd2, 8'd1);
    do_restock(2'd1, 8'd1);
    start_pulse(16'd30);
    wait_done("g30");
    check("g30_short", {31'd0, short_change}, 32'd1);
    check("g30_rem", {16'd0, remaining}, 32'd15);
    check("g30_ncoin", coin_log.size(), 32'd2);
    check("g30_c0", {30'd0, coin_at(0)}, 32'd2);
    check("g30_c1", {30'd0, coin_at(1)}, 32'd1);
    check("g30_d", {24'd0, dime_cnt}, 32'd0);
    check("g30_n", {24'd0, nickel_cnt}, 32'd0);

    // non-multiple of five
    do_reset();
    do_restock(2'd1, 8'd3);
    start_pulse(16'd7);
    wait_done("b7");
    check("b7_short", {31'd0, short_change}, 32'd1);
    check("b7_rem", {16'd0, remaining}, 32'd2);
    check("b7_ncoin", coin_log.size(), 32'd1);
    check("b7_c0", {30'd0, coin_at(0)}, 32'd1);
    check("b7_n", {24'd0, nickel_cnt}, 32'd2);

    // saturation and NONE restock
    do_reset();
    do_restock(2'd1, 8'd250);
    do_restock(2'd1, 8'd10);
    check("sat_n", {24'd0, nickel_cnt}, 32'd255);
    do_restock(2'd0, 8'd5);
    check("none_n", {24'd0, nickel_cnt}, 32'd255);
    check("none_d", {24'd0, dime_cnt}, 32'd0);
    check("none_q", {24'd0, quarter_cnt}, 32'd0);

    // restock and start in the same cycle: SELECT sees the new nickel
    do_reset();
    @(negedge clk);
    start = 1'b1; balance = 16'd5;
    restock = 1'b1; restock_type = 2'd1; restock_count = 8'd1;
    @(negedge clk);
    start = 1'b0; restock = 1'b0; restock_type = 2'd0; restock_count = '0;
    wait_done("same");
    check("same_short", {31'd0, short_change}, 32'd0);
    check("same_rem", {16'd0, remaining}, 32'd0);
    check("same_n", {24'd0, nickel_cnt}, 32'd0);

    // reset during an unanswered request
    do_reset();
    do_restock(2'd3, 8'd1);
    ack_en = 1'b0;
    start_pulse(16'd25);
    @(negedge clk);
    check("hs_req", {31'd0, coin_req}, 32'd1);
    check("hs_type", {30'd0, coin_type}, 32'd3);
    do_restock(2'd3, 8'd5);
    check("busy_restock_q", {24'd0, quarter_cnt}, 32'd1);
    @(posedge clk);
    #3;
    hrst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, coin_req}, 32'd0);
    check("mid_rst_q", {24'd0, quarter_cnt}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    ack_en = 1'b1;
    hrst_n = 1'b1;
    coin_log.delete();
    do_restock(2'd3, 8'd1);
    start_pulse(16'd25);
    wait_done("post_rst");
    check("post_rst_short", {31'd0, short_change}, 32'd0);
    check("post_rst_rem", {16'd0, remaining}, 32'd0);
    check("post_rst_c0", {30'd0, coin_at(0)}, 32'd3);

`ifdef VM2002_HOPPER_TIMEOUT_EN
    begin
      int n_req;
      do_reset();
      do_restock(2'd3, 8'd1);
      ack_en = 1'b0;
      start_pulse(16'd25);
      @(negedge clk);
      n_req = 0;
      while (coin_req && n_req < 400) begin
        n_req++;
        @(negedge clk);
      end
      check("to_cycles", n_req, 32'd255);
      check("to_req", {31'd0, coin_req}, 32'd0);
      check("to_done", {31'd0, done}, 32'd1);
      check("to_short", {31'd0, short_change}, 32'd1);
      check("to_fault", {31'd0, fault}, 32'd1);
      check("to_rem", {16'd0, remaining}, 32'd25);
      check("to_q", {24'd0, quarter_cnt}, 32'd1);
      @(negedge clk);
      check("to_sticky", {31'd0, fault}, 32'd1);
      ack_en = 1'b1;
      start_pulse(16'd25);
      check("to_clear", {31'd0, fault}, 32'd0);
      wait_done("to_retry");
      check("to_retry_rem", {16'd0, remaining}, 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
